rr_arb4: RTL
============

Name: rr_arb4

Overview:
- Four-requester round-robin arbiter that shares a single resource slot among requesters 0..3.
- Internally it registers a 2-bit grant index and a valid flag. It drives a one-hot grant vector through the team's 2-to-4 decoder, with the valid flag used as the decoder enable.
- It sits in front of any shared datapath resource, such as a bus, a display digit or a memory port, where exactly one requester may own the resource at a time.
- A hold-time limit keeps any one requester from starving the others.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced hand-off when another requester is waiting. Legal range 2..255.
- CW, 8: width of the hold counter. Must satisfy 2^CW > MAX_HOLD.

Ports:
- CLK     input   1  system clock; all state changes on the rising edge.
- RST     input   1  synchronous, active-high reset.
- REQ     input   4  request vector; REQ[i] high means requester i wants the resource.
- GNT     output  4  one-hot grant, equal to decode(GNT_ID) gated by GNT_VLD; all zero when idle.
- GNT_ID  output  2  index of the current owner; valid only while GNT_VLD is high.
- GNT_VLD output  1  a grant is active.
- TMO     output  1  one-cycle pulse on the cycle a forced hand-off takes effect.

Behaviour:
- Clock and reset:
  - One clock, CLK. RST is synchronous and active-high.
  - While RST is sampled high at a rising edge: state becomes IDLE, GNT_ID=2'd0, GNT_VLD=0, GNT=4'b0000, TMO=0, HOLD_CNT=0, LAST=2'd3.
  - Because LAST resets to 3, requester 0 has top priority after reset.
- Reset mid-grant: the grant drops on the edge where RST is sampled, with no hand-off and no TMO.
- Winner search (combinational, excluding index X):
  - Scan indices LAST+1, LAST+2, LAST+3, LAST+4, all modulo 4, with wrap-around.
  - The first i with REQ[i]=1 and i≠X wins. X is "none" in IDLE.
- IDLE:
  - If REQ==0: stay in IDLE.
  - Otherwise: on the next edge, GNT_ID=winner, GNT_VLD=1, HOLD_CNT=0, go to GRANT.
  - Latency: request sampled at edge n gives GNT high after edge n, i.e. one cycle.
- GRANT, evaluated every edge with owner O=GNT_ID, in priority order:
  - a) REQ[O]=0 (owner released):
    - LAST=O.
    - If any other REQ is high: grant the winner (search from O+1) on the same edge, HOLD_CNT=0, stay in GRANT. This is a zero-bubble hand-off.
    - Otherwise: GNT_VLD=0 and go to IDLE.
  - b) REQ[O]=1 and HOLD_CNT==MAX_HOLD-1 and another request is pending:
    - Forced hand-off: LAST=O, grant the winner excluding O, HOLD_CNT=0, TMO=1 for that one cycle.
    - The preempted requester re-enters arbitration normally and waits its turn.
  - c) REQ[O]=1 with no other request pending: keep the grant. HOLD_CNT increments but saturates at MAX_HOLD-1.
  - d) Otherwise: keep the grant and increment HOLD_CNT.
- TMO is 0 in every cycle except the forced-hand-off cycle.
- GNT is always one-hot or zero. GNT is never non-zero while GNT_VLD=0.
- REQ is sampled only on edges. A requester whose request is held only between edges is never granted.
- GNT_ID holds its last value while GNT_VLD=0. Consumers must ignore it in that state.

Decomposition:
- Shared package (rr_arb_pkg), holding:
  - State encoding constants: IDLE=1'b0, GRANT=1'b1.
  - Requester count constant NREQ=4.
  - Index width constant IW=2.
- Sub-module: reuse the existing 2-to-4 decoder for the one-hot grant vector.
  - Enable is GNT_VLD, address is GNT_ID, output is GNT.
  - Arbiter and counter logic stay in rr_arb4.

Test Plan:
- Reset priority: assert RST, then release; REQ=4'b1111 -> after 1 cycle GNT=4'b0001, GNT_ID=0, GNT_VLD=1, TMO=0.
- Rotation with zero-bubble hand-off:
  - REQ=4'b1111, and each owner drops its bit 2 cycles after being granted.
  - Required: grants go 0->1->2->3->0, with no cycle of GNT_VLD=0 between them.
- Idle return: a single requester REQ=4'b0100 held 3 cycles then dropped -> GNT=4'b0100 for 3 cycles, then GNT=0 and GNT_VLD=0 one cycle after the drop.
- Timeout (MAX_HOLD=8):
  - REQ[1] held continuously, REQ[3] asserted 2 cycles later.
  - Required: GNT=4'b0010 for exactly 8 cycles, then GNT=4'b1000 with TMO=1 for one cycle. After requester 3 releases, the grant returns to 1.
- Lone hog: REQ=4'b0001 for 20 cycles -> GNT=4'b0001 throughout, TMO never asserted, HOLD_CNT saturates at 7.
- Reset mid-grant:
  - REQ=4'b0110 with owner 1, then RST asserted for 1 cycle.
  - Required: GNT=0 on that edge, and the next grant goes to 1, since LAST=3 and requester 1 is scanned first.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state encoding, sizing constants and the round-robin winner search
package rr_arb_pkg;

    localparam int NREQ = 4;
    localparam int IW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Scan last+1 .. last+4 (mod 4); result is {found, index} of the first requester hit
    function automatic logic [IW:0] pickNext(input logic [NREQ-1:0] req, input logic [IW-1:0] last);
        logic [IW:0] r;
        logic [IW-1:0] idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + IW'(k);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb4_dec.sv
// rr_arb4_dec: 2-to-4 one-hot decoder with enable
module rr_arb4_dec (
    input  logic       en,
    input  logic [1:0] addr,
    output logic [3:0] y
);

    assign y = en ? 4'b0001 << addr : 4'b0000;

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with hold-time limit and forced hand-off
module rr_arb4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] GNT,
    output logic [IW-1:0]   GNT_ID,
    output logic            GNT_VLD,
    output logic            TMO
);

    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    state_t state, stateNext;
    logic [IW-1:0] gntId, idNext, last, lastNext;
    logic [CW-1:0] holdCnt, holdNext;
    logic tmo, tmoNext;
    logic [NREQ-1:0] others;
    logic [IW:0] winIdle, winOther;

    // Next grant decision: idle pick, release hand-off, forced hand-off, or keep with counting
    always_comb begin
        stateNext = state;
        idNext = gntId;
        lastNext = last;
        holdNext = holdCnt;
        tmoNext = 1'b0;
        others = REQ & ~(NREQ'(1) << gntId);
        winIdle = pickNext(REQ, last);
        winOther = pickNext(others, gntId);
        if (state == IDLE) begin
            if (winIdle[IW]) begin
                stateNext = GRANT;
                idNext = winIdle[IW-1:0];
                holdNext = '0;
            end
        end else if (!REQ[gntId]) begin
            lastNext = gntId;
            stateNext = winOther[IW] ? GRANT : IDLE;
            idNext = winOther[IW] ? winOther[IW-1:0] : gntId;
            holdNext = '0;
        end else if (winOther[IW] && holdCnt == HOLD_MAX) begin
            lastNext = gntId;
            idNext = winOther[IW-1:0];
            holdNext = '0;
            tmoNext = 1'b1;
        end else begin
            holdNext = (holdCnt == HOLD_MAX) ? holdCnt : holdCnt + 1'b1;
        end
    end

    // State registers; LAST resets to 3 so requester 0 is scanned first
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            gntId <= '0;
            last <= IW'(NREQ - 1);
            holdCnt <= '0;
            tmo <= 1'b0;
        end else begin
            state <= stateNext;
            gntId <= idNext;
            last <= lastNext;
            holdCnt <= holdNext;
            tmo <= tmoNext;
        end
    end

    assign GNT_ID = gntId;
    assign GNT_VLD = state == GRANT;
    assign TMO = tmo;

    rr_arb4_dec uDec (
        .en  (GNT_VLD),
        .addr(gntId),
        .y   (GNT)
    );

endmodule
